// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the two-port Wishbone memory arbiter.
// State and grant encodings, wait-counter sizing and the round-robin pick rule.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // A limit of zero still needs a one-bit counter so the port list stays legal.
  function automatic int unsigned wait_cnt_width(input int unsigned limit);
    int unsigned w;
    if (limit == 32'd0) begin
      w = 32'd1;
    end else begin
      w = $clog2(limit + 32'd1);
    end
    return w;
  endfunction

  function automatic grant_e rr_pick(input logic instr_req, input logic data_req,
                                     input grant_e last);
    grant_e pick;
    if (instr_req && data_req) begin
      if (last == GRANT_DATA) begin
        pick = GRANT_INSTR;
      end else begin
        pick = GRANT_DATA;
      end
    end else if (instr_req) begin
      pick = GRANT_INSTR;
    end else begin
      pick = GRANT_DATA;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-state counter for one arbitrated transaction.
// Saturates at all ones; a zero limit never expires.
module wb_timeout_counter #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, increment stops at saturation.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (limit_i != {CNT_W{1'b0}}) && (count_q >= limit_i);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory master between an instruction
// (read-only) port and a data port, with an optional per-transaction wait timeout.
module wb_mem_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cyc_i,
  input  logic                    i_stb_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic [DATA_WIDTH-1:0]   i_data_o,
  output logic                    i_ack_o,
  input  logic                    d_cyc_i,
  input  logic                    d_stb_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_sel_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_data_i,
  output logic [DATA_WIDTH-1:0]   d_data_o,
  output logic                    d_ack_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  input  logic [DATA_WIDTH-1:0]   m_data_i,
  input  logic                    m_ack_i,
  output logic                    timeout_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = wait_cnt_width(TIMEOUT_CYCLES);

  arb_state_e             state_q;
  grant_e                 last_grant_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [SEL_W-1:0]       sel_q;
  logic [DATA_WIDTH-1:0]  wdata_q;

  logic   instr_req;
  logic   data_req;
  logic   busy;
  logic   owner_cyc;
  logic   abort;
  logic   mem_done;
  logic   timed_out;
  logic   xfer_end;
  logic   expired;
  grant_e winner;

  assign instr_req = i_cyc_i & i_stb_i;
  assign data_req  = d_cyc_i & d_stb_i;
  assign busy      = (state_q != IDLE);
  assign winner    = rr_pick(instr_req, data_req, last_grant_q);

  // Cycle line of whichever requester currently owns the bus.
  always_comb begin
    owner_cyc = 1'b0;
    case (state_q)
      GRANT_I: owner_cyc = i_cyc_i;
      GRANT_D: owner_cyc = d_cyc_i;
      default: owner_cyc = 1'b0;
    endcase
  end

  // A dropped cycle line beats both ack and timeout; a real ack beats timeout.
  assign abort     = busy & ~owner_cyc;
  assign mem_done  = busy & owner_cyc & m_ack_i;
  assign timed_out = busy & owner_cyc & ~m_ack_i & expired;
  assign xfer_end  = mem_done | timed_out;

  wb_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (~busy),
    .enable_i  (busy & ~m_ack_i),
    .limit_i   (CNT_W'(TIMEOUT_CYCLES)),
    .expired_o (expired)
  );

  // Requester responses: data is only visible in the ack cycle, zero on timeout.
  always_comb begin
    i_ack_o  = 1'b0;
    i_data_o = {DATA_WIDTH{1'b0}};
    d_ack_o  = 1'b0;
    d_data_o = {DATA_WIDTH{1'b0}};
    if (state_q == GRANT_I) begin
      i_ack_o  = xfer_end;
      i_data_o = mem_done ? m_data_i : {DATA_WIDTH{1'b0}};
    end else if (state_q == GRANT_D) begin
      d_ack_o  = xfer_end;
      d_data_o = mem_done ? m_data_i : {DATA_WIDTH{1'b0}};
    end else begin
      i_ack_o = 1'b0;
      d_ack_o = 1'b0;
    end
  end

  // Arbitration FSM; latches are cleared on exit so master outputs read 0 in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DATA;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      we_q         <= 1'b0;
      sel_q        <= {SEL_W{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_req || data_req) begin
            last_grant_q <= winner;
            if (winner == GRANT_INSTR) begin
              state_q <= GRANT_I;
              addr_q  <= i_addr_i;
              we_q    <= 1'b0;
              sel_q   <= {SEL_W{1'b1}};
              wdata_q <= {DATA_WIDTH{1'b0}};
            end else begin
              state_q <= GRANT_D;
              addr_q  <= d_addr_i;
              we_q    <= d_we_i;
              sel_q   <= d_sel_i;
              wdata_q <= d_data_i;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (abort || xfer_end) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            we_q    <= 1'b0;
            sel_q   <= {SEL_W{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= {ADDR_WIDTH{1'b0}};
          we_q    <= 1'b0;
          sel_q   <= {SEL_W{1'b0}};
          wdata_q <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign m_cyc_o   = busy;
  assign m_stb_o   = busy;
  assign m_we_o    = we_q;
  assign m_sel_o   = sel_q;
  assign m_addr_o  = addr_q;
  assign m_data_o  = wdata_q;
  assign timeout_o = timed_out;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed and randomized bench for wb_mem_arbiter against a transaction-level
// model of round-robin arbitration, memory wait states and timeouts.
module tb_wb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cyc_i, i_stb_i;
  logic [31:0] i_addr_i, i_data_o;
  logic        i_ack_o;
  logic        d_cyc_i, d_stb_i, d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i, d_data_i, d_data_o;
  logic        d_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_addr_o, m_data_o, m_data_i;
  logic        m_ack_i, timeout_o;

  wb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_data_i(d_data_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o),
    .m_data_o(m_data_o), .m_data_i(m_data_i), .m_ack_i(m_ack_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  logic [137:0] all_o;
  assign all_o = {i_data_o, i_ack_o, d_data_o, d_ack_o, m_cyc_o, m_stb_o, m_we_o,
                  m_sel_o, m_addr_o, m_data_o, timeout_o};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: fixed or random wait states, optionally never acking.
  int  rsp_waits_cfg = 0;
  bit  rsp_never_cfg = 1'b0;
  bit  rsp_rand = 1'b0;
  bit  rsp_force_ack = 1'b0;
  bit  rsp_seen = 1'b0;
  int  rsp_left = 0;
  int  cur_waits = 0;
  bit  cur_never = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a + 32'd3;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (!m_stb_o) begin
      rsp_seen = 1'b0;
      m_ack_i  = rsp_force_ack;
      m_data_i = $urandom;
    end else begin
      if (!rsp_seen) begin
        rsp_seen = 1'b1;
        if (rsp_rand) begin
          cur_waits = $urandom_range(0, 3);
          cur_never = ($urandom_range(0, 9) == 0);
        end else begin
          cur_waits = rsp_waits_cfg;
          cur_never = rsp_never_cfg;
        end
        rsp_left = cur_waits;
      end else if (rsp_left > 0) begin
        rsp_left--;
      end
      if (rsp_left == 0 && !cur_never) begin
        m_ack_i  = 1'b1;
        m_data_i = mem_rd(m_addr_o);
      end else begin
        m_ack_i  = 1'b0;
        m_data_i = $urandom;
      end
    end
  endtask

  task automatic samp();
    #2;
  endtask

  task automatic drop_all();
    i_cyc_i = 1'b0; i_stb_i = 1'b0; i_addr_i = 32'h0;
    d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0; d_sel_i = 4'h0;
    d_addr_i = 32'h0; d_data_i = 32'h0;
  endtask

  task automatic do_reset();
    tick(); drop_all(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  // Transaction-level model: pending requests, round-robin winner, expected completion cycle.
  bit          pend[2];
  bit          done[2];
  bit          snap[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_data[2];
  logic        p_we[2];
  logic [3:0]  p_sel[2];
  int          m_last = 1;
  bit          m_busy = 1'b0;
  bit          m_prev_complete = 1'b0;
  int          m_port = 0;
  int          m_cnt = 0;
  int          req_pct = 0;
  int          grant_log[$];

  task automatic eng_cycle();
    logic [66:0] exp_rsp;
    bit          complete;
    tick();
    if (m_busy && m_prev_complete) begin
      m_busy = 1'b0;
    end else if (!m_busy && (snap[0] || snap[1])) begin
      m_port = (snap[0] && snap[1]) ? (1 - m_last) : (snap[0] ? 0 : 1);
      m_last = m_port;
      m_busy = 1'b1;
      m_cnt  = 0;
      grant_log.push_back(m_port);
    end
    m_prev_complete = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (done[p]) begin
        pend[p] = 1'b0;
        done[p] = 1'b0;
      end
      if (!pend[p] && $urandom_range(1, 100) <= req_pct) begin
        pend[p]   = 1'b1;
        p_addr[p] = $urandom;
        p_data[p] = (p == 0) ? 32'h0 : $urandom;
        p_we[p]   = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        p_sel[p]  = (p == 0) ? 4'hF : 4'($urandom_range(0, 15));
      end
    end
    i_cyc_i = pend[0]; i_stb_i = pend[0]; i_addr_i = p_addr[0];
    d_cyc_i = pend[1]; d_stb_i = pend[1]; d_addr_i = p_addr[1];
    d_data_i = p_data[1]; d_we_i = p_we[1]; d_sel_i = p_sel[1];
    snap[0] = pend[0];
    snap[1] = pend[1];
    samp();
    check("eng_cyc", m_cyc_o, m_busy);
    if (m_busy) begin
      m_cnt++;
      check("eng_master", {m_we_o, m_sel_o, m_addr_o, m_data_o},
            {p_we[m_port], p_sel[m_port], p_addr[m_port], p_data[m_port]});
      complete = cur_never ? (m_cnt == TO + 1) : (m_cnt == cur_waits + 1);
      exp_rsp = '0;
      if (complete) begin
        exp_rsp[66 - m_port] = 1'b1;
        exp_rsp[64] = cur_never;
        if (!cur_never) begin
          if (m_port == 0) exp_rsp[63:32] = mem_rd(p_addr[0]);
          else             exp_rsp[31:0]  = mem_rd(p_addr[1]);
        end
        done[m_port] = 1'b1;
        m_prev_complete = 1'b1;
      end
      check("eng_resp", {i_ack_o, d_ack_o, timeout_o, i_data_o, d_data_o}, exp_rsp);
    end else begin
      check("eng_idle_resp", {i_ack_o, d_ack_o, timeout_o, i_data_o, d_data_o}, 67'h0);
    end
  endtask

  initial begin
    rst = 1'b1; drop_all(); m_ack_i = 1'b0; m_data_i = 32'h0;
    pend[0] = 0; pend[1] = 0; done[0] = 0; done[1] = 0; snap[0] = 0; snap[1] = 0;
    rsp_force_ack = 1'b1;
    repeat (2) tick();
    samp(); check("reset_outputs", all_o, 138'h0);
    rsp_force_ack = 1'b0;
    tick(); rst = 1'b0;
    samp(); check("post_reset_outputs", all_o, 138'h0);

    // Lone instruction read with two wait states.
    tick(); i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0010; rsp_waits_cfg = 2;
    samp(); check("ir_idle", m_cyc_o, 1'b0);
    tick(); samp();
    check("ir_master", {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_addr_o, m_data_o},
          {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0});
    check("ir_wait1", {i_ack_o, i_data_o}, 33'h0);
    tick(); samp(); check("ir_wait2", {i_ack_o, i_data_o, d_ack_o}, 34'h0);
    tick(); samp(); check("ir_ack", {i_ack_o, i_data_o, d_ack_o}, {1'b1, 32'h0000_0013, 1'b0});
    tick(); drop_all(); samp(); check("ir_after", {m_cyc_o, i_ack_o, i_data_o}, 34'h0);
    tick(); samp(); check("ir_no_reissue", m_cyc_o, 1'b0);

    // Simultaneous requests after reset: instruction first, then data write.
    do_reset();
    tick();
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0020;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'h3;
    d_addr_i = 32'h8000_0004; d_data_i = 32'hCAFE_BABE; rsp_waits_cfg = 0;
    samp(); check("tie_idle", m_cyc_o, 1'b0);
    tick(); samp();
    check("tie_i_master", {m_cyc_o, m_we_o, m_sel_o, m_addr_o, m_data_o},
          {1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0});
    check("tie_i_ack", {i_ack_o, i_data_o, d_ack_o}, {1'b1, 32'h0000_0023, 1'b0});
    tick(); i_cyc_i = 1'b0; i_stb_i = 1'b0;
    samp(); check("tie_gap", {m_cyc_o, d_ack_o}, 2'b00);
    tick(); samp();
    check("tie_d_master", {m_cyc_o, m_we_o, m_sel_o, m_addr_o, m_data_o},
          {1'b1, 1'b1, 4'h3, 32'h8000_0004, 32'hCAFE_BABE});
    check("tie_d_ack", {d_ack_o, d_data_o, i_ack_o}, {1'b1, 32'h8000_0007, 1'b0});
    tick(); drop_all(); samp(); check("tie_done", m_cyc_o, 1'b0);

    // Memory never answers: timeout in the ninth grant cycle.
    tick(); rsp_never_cfg = 1'b1;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF;
    d_addr_i = 32'h0000_0100; d_data_i = 32'h0000_1234;
    samp();
    for (int k = 1; k <= TO; k++) begin
      tick(); samp(); check("to_wait", {d_ack_o, timeout_o, m_cyc_o}, 3'b001);
    end
    tick(); samp();
    check("to_fire", {d_ack_o, timeout_o, d_data_o, m_cyc_o}, {1'b1, 1'b1, 32'h0, 1'b1});
    tick(); drop_all(); rsp_never_cfg = 1'b0;
    samp(); check("to_after", {m_cyc_o, timeout_o, d_ack_o}, 3'b000);

    // Data read aborted on its second wait cycle; a stray ack afterwards is ignored.
    tick(); d_cyc_i = 1'b1; d_stb_i = 1'b1; d_addr_i = 32'h0000_0200; rsp_waits_cfg = 5;
    samp();
    tick(); samp(); check("ab_grant", m_cyc_o, 1'b1);
    tick(); d_cyc_i = 1'b0; samp(); check("ab_cycle", {d_ack_o, timeout_o}, 2'b00);
    tick(); d_stb_i = 1'b0; rsp_force_ack = 1'b1;
    samp(); check("ab_drop", {m_cyc_o, d_ack_o, d_data_o, i_ack_o, timeout_o}, 36'h0);
    tick(); samp(); check("ab_stray_ack", {m_cyc_o, d_ack_o, d_data_o, i_ack_o, timeout_o}, 36'h0);
    rsp_force_ack = 1'b0;

    // Reset in the middle of an instruction grant.
    tick(); i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0040; rsp_waits_cfg = 3;
    samp();
    tick(); samp(); check("rm_granted", m_cyc_o, 1'b1);
    tick(); rst = 1'b1; samp(); check("rm_outputs", all_o, 138'h0);
    tick(); rst = 1'b0; rsp_waits_cfg = 0;
    i_addr_i = 32'h0000_0044;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0048;
    samp(); check("rm_released", all_o, 138'h0);
    tick(); samp(); check("rm_tie", {m_addr_o, i_ack_o, d_ack_o}, {32'h0000_0044, 1'b1, 1'b0});
    tick(); drop_all(); samp();
    tick(); samp(); check("rm_quiet", m_cyc_o, 1'b0);

    // Both ports permanently requesting, zero-wait memory: strict alternation.
    do_reset();
    m_last = 1; m_busy = 1'b0; m_prev_complete = 1'b0; grant_log.delete();
    rsp_rand = 1'b0; rsp_waits_cfg = 0; rsp_never_cfg = 1'b0; req_pct = 100;
    for (int k = 0; k < 80 && grant_log.size() < 6; k++) eng_cycle();
    check("rr_count", grant_log.size() >= 6, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) check("rr_alt", grant_log[k], k % 2);
    end

    // Random traffic with random wait states and occasional timeouts.
    rsp_rand = 1'b1; req_pct = 35;
    repeat (400) eng_cycle();
    req_pct = 0;
    for (int k = 0; k < 80 && (m_busy || pend[0] || pend[1]); k++) eng_cycle();
    check("drain", {m_busy, pend[0], pend[1]}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
